// File: rtl/filter_capture_pkg.sv
// Shared types, default parameters and helpers for the filter output capture block.
package filter_capture_pkg;

  localparam int unsigned CAP_DATA_W = 32;
  localparam int unsigned CAP_DEPTH  = 64;
  localparam int unsigned CAP_ADDR_W = 6;
  localparam int unsigned CAP_SKIP   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  // |s| for a two's-complement sample; the most negative value clamps to the largest positive.
  function automatic logic [CAP_DATA_W-1:0] sat_abs(input logic [CAP_DATA_W-1:0] s);
    logic [CAP_DATA_W-1:0] min_neg;
    logic [CAP_DATA_W-1:0] max_pos;
    min_neg = {1'b1, {(CAP_DATA_W-1){1'b0}}};
    max_pos = {1'b0, {(CAP_DATA_W-1){1'b1}}};
    if (!s[CAP_DATA_W-1]) begin
      return s;
    end
    if (s == min_neg) begin
      return max_pos;
    end
    return ~s + CAP_DATA_W'(1);
  endfunction

endpackage

// File: rtl/filter_capture_ram.sv
// Capture buffer: one synchronous write port, one registered read port.
module capture_ram
  import filter_capture_pkg::*;
#(
  parameter int unsigned DATA_W = CAP_DATA_W,
  parameter int unsigned DEPTH  = CAP_DEPTH,
  parameter int unsigned ADDR_W = CAP_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage array is never reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/filter_capture.sv
// Discards filter settling samples after arm, captures a fixed window with peak tracking,
// then serves the window through a registered read port.
module filter_capture
  import filter_capture_pkg::*;
#(
  parameter int unsigned DATA_W = CAP_DATA_W,
  parameter int unsigned DEPTH  = CAP_DEPTH,
  parameter int unsigned ADDR_W = CAP_ADDR_W,
  parameter int unsigned SKIP   = CAP_SKIP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic                     in_valid,
  input  logic                     arm,
  output logic                     busy,
  output logic                     done,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        peak_abs
);

  localparam int unsigned SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  cap_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic              busy_q, done_q, rd_valid_q;
  logic              wr_en_c;
  logic              rd_ok_c;
  logic [DATA_W-1:0] sample_abs_c;

  assign sample_abs_c = sat_abs(in_sample);
  // Reads are only honoured while the buffer is stable.
  assign rd_ok_c      = rd_en && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    peak_d     = peak_q;
    wr_en_c    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          skip_cnt_d = '0;
          wr_ptr_d   = '0;
          peak_d     = '0;
          state_d    = (SKIP > 0) ? SETTLE : CAPTURE;
        end
      end
      SETTLE: begin
        if (in_valid) begin
          skip_cnt_d = skip_cnt_q + SKIP_W'(1);
          if (skip_cnt_d == SKIP_W'(SKIP)) begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (in_valid) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (sample_abs_c > peak_q) begin
            peak_d = sample_abs_c;
          end
          if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      skip_cnt_q <= '0;
      wr_ptr_q   <= '0;
      peak_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      peak_q     <= peak_d;
      busy_q     <= (state_d == SETTLE) || (state_d == CAPTURE);
      done_q     <= (state_d == DONE);
      rd_valid_q <= rd_ok_c;
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_sample),
    .rd_en_i   (rd_ok_c),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign peak_abs = peak_q;

endmodule

// File: tb/tb_filter_capture.sv
// Scoreboard bench for filter_capture: one instance with settling skip, one with SKIP=0.
module tb_filter_capture;

  logic clk;
  logic rst;

  logic signed [31:0] in_sample, in_sample0;
  logic               in_valid, in_valid0;
  logic               arm, arm0;
  logic               busy, busy0;
  logic               done, done0;
  logic               rd_en, rd_en0;
  logic [5:0]         rd_addr, rd_addr0;
  logic [31:0]        rd_data, rd_data0;
  logic               rd_valid, rd_valid0;
  logic [31:0]        peak_abs, peak_abs0;

  int n_err;
  int n_checks;
  logic [31:0] exp_q[$];
  logic [31:0] exp_q0[$];

  filter_capture #(.DATA_W(32), .DEPTH(64), .ADDR_W(6), .SKIP(16)) u_dut (
    .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid), .arm(arm),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .peak_abs(peak_abs)
  );

  filter_capture #(.DATA_W(32), .DEPTH(64), .ADDR_W(6), .SKIP(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_sample(in_sample0), .in_valid(in_valid0), .arm(arm0),
    .busy(busy0), .done(done0), .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .peak_abs(peak_abs0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Read monitors: every rd_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_stray_a: rd_valid=1 data=%0h, required no read", rd_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_err++;
          $display("FAIL rd_data_a: got %0h, required %0h", rd_data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rd_valid0 === 1'b1) begin
      n_checks++;
      if (exp_q0.size() == 0) begin
        n_err++;
        $display("FAIL rd_stray_b: rd_valid=1 data=%0h, required no read", rd_data0);
      end else begin
        logic [31:0] e;
        e = exp_q0.pop_front();
        if (rd_data0 !== e) begin
          n_err++;
          $display("FAIL rd_data_b: got %0h, required %0h", rd_data0, e);
        end
      end
    end
  end

  task automatic read_a(input int n, input logic [31:0] e0);
    for (int a = 0; a < n; a++) begin
      rd_en   = 1'b1;
      rd_addr = 6'(a);
      exp_q.push_back(e0 + 32'(a));
      step();
    end
    rd_en = 1'b0;
    step();
    step();
  endtask

  task automatic read_b(input logic [5:0] a, input logic [31:0] e);
    rd_en0   = 1'b1;
    rd_addr0 = a;
    exp_q0.push_back(e);
    step();
    rd_en0 = 1'b0;
    step();
  endtask

  // Arm instance A and stream base..base+79 continuously; done must rise right after the 80th.
  task automatic capture_a(input logic [31:0] base, input string tag);
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk({tag, "_busy_after_arm"}, 32'(busy), 32'd1);
    chk({tag, "_peak_cleared"}, peak_abs, 32'd0);
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'b1;
      in_sample = base + 32'(i);
      step();
      if (i == 78) chk({tag, "_done_early"}, 32'(done), 32'd0);
    end
    in_valid = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_peak"}, peak_abs, base + 32'd79);
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    rst = 1'b0;
    arm = 1'b1;       in_valid = 1'b1;  in_sample = 32'sd5;  rd_en = 1'b0;  rd_addr = '0;
    arm0 = 1'b1;      in_valid0 = 1'b1; in_sample0 = 32'sd5; rd_en0 = 1'b0; rd_addr0 = '0;

    // Reset held with arm and in_valid asserted.
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_peak", peak_abs, 32'd0);
    end
    chk("rst_rd_data", rd_data, 32'd0);
    rst = 1'b1; arm = 1'b0; in_valid = 1'b0; arm0 = 1'b0; in_valid0 = 1'b0;
    step();

    // Basic capture: first 16 samples are settling, window is 16..79.
    capture_a(32'd0, "basic");
    read_a(64, 32'd16);
    chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
    chk("rd_data_hold", rd_data, 32'd79);

    // SKIP=0 instance, gapped input with most-negative sample.
    arm0 = 1'b1;
    step();
    arm0 = 1'b0;
    chk("gap_busy", 32'(busy0), 32'd1);
    for (int k = 0; k < 64; k++) begin
      in_valid0  = 1'b1;
      in_sample0 = (k == 0) ? 32'sh8000_0000 : (k == 1) ? 32'sd5 : 32'(k);
      step();
      in_valid0 = 1'b0;
      if (k == 62) chk("gap_done_early", 32'(done0), 32'd0);
      if (k < 63) step();
    end
    chk("gap_done", 32'(done0), 32'd1);
    chk("gap_peak_sat", peak_abs0, 32'h7FFF_FFFF);
    // Samples arriving in DONE must not disturb the buffer.
    for (int k = 0; k < 4; k++) begin
      in_valid0  = 1'b1;
      in_sample0 = 32'sd999;
      step();
    end
    in_valid0 = 1'b0;
    read_b(6'd0, 32'h8000_0000);
    read_b(6'd1, 32'd5);
    read_b(6'd63, 32'd63);
    chk("gap_peak_hold", peak_abs0, 32'h7FFF_FFFF);

    // Read and arm pulsed mid-capture must be ignored.
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'b1;
      in_sample = 32'd100 + 32'(i);
      if (i == 40) begin
        rd_en   = 1'b1;
        rd_addr = 6'd0;
        arm     = 1'b1;
      end
      step();
      rd_en = 1'b0;
      arm   = 1'b0;
      if (i == 40) chk("illegal_rd_valid", 32'(rd_valid), 32'd0);
      if (i == 41) chk("illegal_rd_valid_late", 32'(rd_valid), 32'd0);
      if (i == 78) chk("illegal_done_early", 32'(done), 32'd0);
    end
    in_valid = 1'b0;
    chk("illegal_done", 32'(done), 32'd1);
    chk("illegal_peak", peak_abs, 32'd179);
    read_a(64, 32'd116);

    // Re-arm in DONE together with a read of addr 3.
    rd_en   = 1'b1;
    rd_addr = 6'd3;
    arm     = 1'b1;
    exp_q.push_back(32'd119);
    step();
    rd_en = 1'b0;
    arm   = 1'b0;
    chk("rearm_rd_valid", 32'(rd_valid), 32'd1);
    chk("rearm_busy", 32'(busy), 32'd1);
    chk("rearm_peak", peak_abs, 32'd0);
    chk("rearm_done", 32'(done), 32'd0);

    // Reset after 16 settling + 30 captured samples.
    for (int i = 0; i < 46; i++) begin
      in_valid  = 1'b1;
      in_sample = 32'd200 + 32'(i);
      step();
    end
    chk("midrst_peak_before", peak_abs, 32'd245);
    rst = 1'b0;
    step();
    rst = 1'b1;
    in_valid = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_peak", peak_abs, 32'd0);
    step();
    chk("midrst_idle_done", 32'(done), 32'd0);
    capture_a(32'd300, "fresh");
    read_a(64, 32'd316);

    chk("queue_a_empty", 32'(exp_q.size()), 32'd0);
    chk("queue_b_empty", 32'(exp_q0.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/filter_capture.md
# filter_capture

Sink-side capture block for the FIR filter output stream. It sits behind the transposed filter and has two jobs: discard the filter's settling samples after an arm request, then record a fixed window of consecutive filtered samples into an internal buffer while tracking the peak magnitude. Once the window is full, it exposes the buffer through a registered read port so the verification environment or a host interface can drain it. It is the receiving counterpart to the sample-feeding source that streams the noisy signal into the filter.

## Interface
- DATA_W, 32, width of filtered samples (signed)
- DEPTH, 64, capture window length in samples; power of two
- ADDR_W, 6, log2(DEPTH)
- SKIP, 16, valid samples discarded after arm (filter settling); 0 allowed
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- in_sample  input  DATA_W  signed filtered sample
- in_valid  input  1  in_sample valid this cycle
- arm  input  1  start a new capture (level sampled each cycle)
- busy  output  1  high in SETTLE or CAPTURE
- done  output  1  high in DONE
- rd_en  input  1  read request
- rd_addr  input  ADDR_W  read index, 0 = oldest captured sample
- rd_data  output  DATA_W  registered read data
- rd_valid  output  1  rd_data valid this cycle
- peak_abs  output  DATA_W  max |sample| over the captured window, unsigned

## Operation
- The block has four states: IDLE, SETTLE, CAPTURE, DONE.
- IDLE
  - arm=1 moves to SETTLE if SKIP>0, otherwise directly to CAPTURE.
  - Arming clears skip_cnt, wr_ptr and peak_abs to 0.
- SETTLE
  - Each in_valid increments skip_cnt.
  - On the in_valid that makes skip_cnt reach SKIP, move to CAPTURE. That sample is discarded, not captured.
- CAPTURE
  - Each in_valid writes in_sample to buf[wr_ptr] and increments wr_ptr.
  - On the write with wr_ptr = DEPTH-1, move to DONE. wr_ptr wraps to 0.
- DONE
  - Holds until arm=1, then re-arms exactly as from IDLE.
- arm in SETTLE or CAPTURE is ignored. There is no restart mid-window.
- in_valid in IDLE or DONE is ignored, and buffer contents are preserved.
- Peak tracking: abs = (s<0) ? -s : s. The most negative value, -2^(DATA_W-1), saturates to 2^(DATA_W-1)-1. peak_abs updates to max(peak_abs, abs) on each captured write.
- Reads
  - Accepted only in IDLE or DONE.
  - rd_en in SETTLE or CAPTURE is dropped, and rd_valid stays 0.
- Simultaneous arm and rd_en in DONE: the read is served from the pre-arm contents, and the state moves to SETTLE.

## Timing
- Reset (rst=0 at an edge) gives: state IDLE, busy=0, done=0, rd_valid=0, rd_data=0, peak_abs=0, counters 0.
  - Buffer RAM is not cleared.
  - Reset mid-capture aborts the capture. done does not assert.
- busy rises the cycle after the arm edge. done rises the cycle after the final captured write; busy falls in the same cycle.
- Read latency is 1 cycle: rd_en at edge N gives rd_data/rd_valid at edge N+1.
  - Back-to-back reads are supported at one per cycle.
  - rd_valid is a single-cycle pulse per accepted rd_en.
  - rd_data holds its last value when rd_valid=0.
- peak_abs is registered. It is final in the same cycle done rises.
- Capture throughput is one sample per cycle. in_valid may be continuous or gapped; gaps stall the counters.

## Structure
- Shared package filter_capture_pkg holds:
  - state enum (IDLE, SETTLE, CAPTURE, DONE)
  - default DATA_W, DEPTH, ADDR_W, SKIP constants
  - the saturating-abs function
- Sub-module capture_ram: DEPTH x DATA_W RAM with one synchronous write port and one registered read port; infers block RAM.
- The top level holds the FSM, counters, peak register and read gating.

## Test plan
- Reset check: hold rst=0 for 3 cycles with arm=1 and in_valid=1. Required: busy=0, done=0, rd_valid=0, peak_abs=0 throughout.
- Basic capture: arm once, then stream in_sample = 0..79 with continuous in_valid. Required:
  - done rises 1 cycle after sample 79.
  - Reading addr 0..63 returns 16..79.
  - peak_abs = 79.
- Gapped input and negative saturation: SKIP=0, in_valid on alternate cycles, samples include -2^31 and +5. Required: done after 64 valid samples; peak_abs = 0x7FFFFFFF.
- Illegal access: pulse rd_en and arm during CAPTURE. Required: no rd_valid; capture is not restarted; window contents are unchanged.
- Re-arm: after done, assert arm together with rd_en at addr 3. Required:
  - Old buf[3] is returned with rd_valid.
  - busy=1 next cycle.
  - peak_abs = 0 next cycle.
- Reset mid-capture: drop rst after 30 captured samples. Required: IDLE, done=0; a new arm then captures a full fresh 64-sample window.
